// File: rtl/add_round_key_acc.sv
// AddRoundKey column accumulator.
// Each accepted column word is XORed with its round-key word, or stored as-is
// when key_bypass is set. The result is packed into slot word_cnt of a
// full-state register. Once NUM_WORDS slots are written, the state is
// presented downstream.
//
// Handshake semantics (both ports):
//   A transfer happens on a rising edge where valid & ready are both high.
//   - valid may not depend on ready.
//   - ready may depend on valid's consumer state.
//   - in_ready is combinational:
//       high in FILL, or in FULL while downstream is draining the state this
//       cycle. This lets a new state start with no bubble.
//   - out_valid is registered and is high exactly while the FSM is in FULL.
module add_round_key_acc #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int CNT_W     = $clog2(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_word,
  input  logic [WORD_W-1:0]           key_word,
  input  logic                        key_bypass,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*NUM_WORDS-1:0] out_state,
  output logic [CNT_W-1:0]            word_cnt
);

  localparam int STATE_W = WORD_W * NUM_WORDS;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } fsm_t;

  fsm_t                state;
  logic                accept;
  logic                drain;
  logic                last_slot;
  logic [WORD_W-1:0]   stored;
  logic [STATE_W-1:0]  fill_vec;
  logic [STATE_W-1:0]  restart_vec;

  // Ready and transfer strobes; in FULL a drain frees the register this cycle.
  always_comb begin
    in_ready  = (state == FILL) || ((state == FULL) && out_ready);
    accept    = in_valid && in_ready;
    drain     = out_valid && out_ready;
    last_slot = (word_cnt == CNT_W'(NUM_WORDS - 1));
  end

  // Value to store for the current word: plain column or column XOR key.
  always_comb begin
    stored = key_bypass ? in_word : (in_word ^ key_word);
  end

  // Candidate register contents: current state with slot word_cnt replaced,
  // and a fresh state holding only the new word in slot 0 (MSBs).
  always_comb begin
    fill_vec    = out_state;
    restart_vec = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (word_cnt == CNT_W'(k)) begin
        fill_vec[WORD_W*(NUM_WORDS-k)-1 -: WORD_W] = stored;
      end
    end
    restart_vec[STATE_W-1 -: WORD_W] = stored;
  end

  // FILL/FULL controller with registered outputs; rst, then flush, win.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= FILL;
      word_cnt  <= '0;
      out_state <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            out_state <= fill_vec;
            if (last_slot) begin
              word_cnt  <= '0;
              state     <= FULL;
              out_valid <= 1'b1;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end
        FULL: begin
          if (drain) begin
            state     <= FILL;
            out_valid <= 1'b0;
            if (accept) begin
              out_state <= restart_vec;
              word_cnt  <= CNT_W'(1);
            end else begin
              out_state <= '0;
              word_cnt  <= '0;
            end
          end
        end
        default: begin
          state     <= FILL;
          word_cnt  <= '0;
          out_state <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_round_key_acc.sv
// Directed testbench for add_round_key_acc (WORD_W=32, NUM_WORDS=4).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_add_round_key_acc;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic [31:0]  key_word;
  logic         key_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [1:0]   word_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  logic [127:0] exp_q[$];
  logic [127:0] exp_vec;
  logic [127:0] popped;
  logic [31:0]  words[4];
  logic [31:0]  w;
  logic [31:0]  k;
  logic         b;

  add_round_key_acc #(.WORD_W(32), .NUM_WORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .key_word   (key_word),
    .key_bypass (key_bypass),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .word_cnt   (word_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] wd, input logic [31:0] kw,
                       input logic byp);
    in_valid   = v;
    in_word    = wd;
    key_word   = kw;
    key_bypass = byp;
    #1;
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    words[0] = 32'h0011_2233;
    words[1] = 32'h4455_6677;
    words[2] = 32'h8899_AABB;
    words[3] = 32'hCCDD_EEFF;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_word_cnt",  word_cnt,  0);
    check("reset_out_state", out_state, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready",  in_ready,  1);

    // T1: XOR with 0x01010101, downstream stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, words[i], 32'h0101_0101, 1'b0);
      check("t1_in_ready", in_ready, 1);
      check("t1_no_partial_valid", out_valid, 0);
      tick();
      check("t1_word_cnt", word_cnt, (i + 1) % 4);
      if (i == 1)
        check("t1_partial", out_state, {32'h0110_2332, 32'h4554_6776, 64'h0});
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_state", out_state,
          {32'h0110_2332, 32'h4554_6776, 32'h8998_ABBA, 32'hCDDC_EFFE});

    // T3: FULL, stalled for 5 clocks with a word waiting
    drive(1'b1, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("t3_in_ready_low", in_ready, 0);
      tick();
      check("t3_hold_state", out_state,
            {32'h0110_2332, 32'h4554_6776, 32'h8998_ABBA, 32'hCDDC_EFFE});
      check("t3_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check("t3_in_ready_drain", in_ready, 1);
    tick();
    check("t3_slot0", out_state, {32'hD1A2_B1E0, 96'h0});
    check("t3_word_cnt", word_cnt, 1);
    check("t3_valid_dropped", out_valid, 0);
    out_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 32'(i), 32'hFFFF_FFFF, 1'b1);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("t3_mixed_bypass", out_state, {32'hD1A2_B1E0, 32'h1, 32'h2, 32'h3});
    out_ready = 1'b1;
    tick();
    check("t3_drain_clear", out_state, 0);
    check("t3_drain_cnt", word_cnt, 0);
    check("t3_drain_valid", out_valid, 0);

    // T2: bypass keeps words unchanged
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, words[i], 32'h0101_0101, 1'b1);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("t2_out_valid", out_valid, 1);
    check("t2_out_state", out_state,
          {32'h0011_2233, 32'h4455_6677, 32'h8899_AABB, 32'hCCDD_EEFF});
    out_ready = 1'b1;
    tick();
    check("t2_drain_clear", out_state, 0);

    // T4: streaming three states back-to-back
    exp_vec = '0;
    for (int i = 0; i < 12; i++) begin
      w = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      k = 32'hA5A5_0000 | 32'(i);
      b = (i % 3) == 1;
      drive(1'b1, w, k, b);
      check("t4_in_ready", in_ready, 1);
      if (i % 4 == 0) exp_vec = '0;
      exp_vec[32*(4-(i%4))-1 -: 32] = b ? w : (w ^ k);
      if (i % 4 == 3) exp_q.push_back(exp_vec);
      tick();
      check("t4_out_valid", out_valid, (i % 4) == 3);
      check("t4_out_state", out_state, exp_vec);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("t4_unexpected_state", out_state, 128'hx);
        end else begin
          popped = exp_q.pop_front();
          check("t4_scoreboard", out_state, popped);
        end
      end
    end
    check("t4_queue_empty", exp_q.size(), 0);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("t4_final_drain", out_valid, 0);

    // T5: flush after two words; a flush-cycle word is discarded
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, words[i], 32'h0101_0101, 1'b0);
      tick();
    end
    flush = 1'b1;
    drive(1'b1, 32'h7777_7777, 32'h0, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("t5_cnt", word_cnt, 0);
    check("t5_state", out_state, 0);
    check("t5_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, words[i], 32'h0101_0101, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("t5_clean_valid", out_valid, 1);
    check("t5_clean_state", out_state,
          {32'h0110_2332, 32'h4554_6776, 32'h8998_ABBA, 32'hCDDC_EFFE});

    // T6: reset in FULL with drain and accept pending
    drive(1'b1, 32'h1234_5678, 32'h0, 1'b0);
    check("t6_in_ready_before", in_ready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("t6_state", out_state, 0);
    check("t6_cnt", word_cnt, 0);
    check("t6_valid", out_valid, 0);
    check("t6_in_ready", in_ready, 1);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
